// File: rtl/fxp_pkg.sv
// Shared fixed-point library definitions: default accumulator width, common
// sample/accumulator types and the widen-and-shift helper reused across blocks.
package fxp_pkg;

    localparam int ACC_W = 32;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [7:0]       q8_t;

    // Callers hand in the product already sign-extended via an acc_t cast, so the
    // arithmetic shift keeps the sign and the result is exact while it fits.
    function automatic acc_t fxp_widen_shift(input acc_t prod, input int shift);
        return prod <<< shift;
    endfunction

endpackage

// File: rtl/fxp_pipe_stage.sv
// Single valid/ready register slice. A beat is taken whenever the slice is
// empty or its current beat leaves in the same cycle.
module fxp_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Payload only loads on a real accept, so idle input lanes never disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/fxp_dequant_stream.sv
// Streaming dequantizer: out = (in * scale) <<< min(shift, SHIFT_MAX), two stages.
// Define FXP_DEQ_ZP_EN to add the in_zp zero-point port (asymmetric dequantization).
module fxp_dequant_stream #(
    parameter int N         = 8,
    parameter int S         = 16,
    parameter int SHIFT_W   = 4,
    parameter int SHIFT_MAX = 7,
    parameter int ACC_W     = fxp_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     in_data,
    input  logic signed [S-1:0]     in_scale,
    input  logic [SHIFT_W-1:0]      in_shift,
`ifdef FXP_DEQ_ZP_EN
    input  logic signed [N-1:0]     in_zp,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    shift_clamped
);

    import fxp_pkg::*;

`ifdef FXP_DEQ_ZP_EN
    localparam int DW = N + 1;
`else
    localparam int DW = N;
`endif
    localparam int PW  = DW + S;
    localparam int P1W = PW + SHIFT_W;

    // Exactness rests on the widest product shifted by SHIFT_MAX fitting the output.
    if ((PW + SHIFT_MAX > ACC_W) || (ACC_W > $bits(acc_t)) ||
        (SHIFT_MAX > (1 << SHIFT_W) - 1)) begin : g_widthCheck
        $error("fxp_dequant_stream: N/S/SHIFT_MAX do not fit ACC_W");
    end

    logic signed [DW-1:0]    w_operand;
    logic signed [PW-1:0]    w_prod;
    logic                    w_overShift;
    logic [SHIFT_W-1:0]      w_shiftSat;
    logic                    w_accept;
    logic                    w_s1Valid;
    logic                    w_s2Ready;
    logic [P1W-1:0]          w_s1Payload;
    logic signed [PW-1:0]    w_s1Prod;
    logic [SHIFT_W-1:0]      w_s1Shift;
    logic [ACC_W-1:0]        w_s2Data;
    logic                    r_shiftClamped;

`ifdef FXP_DEQ_ZP_EN
    assign w_operand = DW'(in_data) - DW'(in_zp);
`else
    assign w_operand = in_data;
`endif

    assign w_prod      = PW'(w_operand) * PW'(in_scale);
    assign w_overShift = in_shift > SHIFT_W'(SHIFT_MAX);
    assign w_shiftSat  = w_overShift ? SHIFT_W'(SHIFT_MAX) : in_shift;
    assign w_accept    = in_valid && in_ready;

    fxp_pipe_stage #(.W(P1W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({w_prod, w_shiftSat}),
        .o_valid (w_s1Valid),
        .i_ready (w_s2Ready),
        .o_data  (w_s1Payload)
    );

    assign w_s1Prod  = w_s1Payload[P1W-1:SHIFT_W];
    assign w_s1Shift = w_s1Payload[SHIFT_W-1:0];
    assign w_s2Data  = ACC_W'(fxp_widen_shift(acc_t'(w_s1Prod), int'(w_s1Shift)));

    fxp_pipe_stage #(.W(ACC_W)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_s1Valid),
        .o_ready (w_s2Ready),
        .i_data  (w_s2Data),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_data)
    );

    // Sticky flag: any accepted beat asking for more shift than we honour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shiftClamped <= 1'b0;
        end else if (w_accept && w_overShift) begin
            r_shiftClamped <= 1'b1;
        end
    end

    assign shift_clamped = r_shiftClamped;

endmodule

// File: tb/tb_fxp_dequant_stream.sv
// Self-checking bench for fxp_dequant_stream: vector table plus scoreboard,
// with hand sequences for latency, backpressure and mid-stream reset.
module tb_fxp_dequant_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               inValid;
    logic               inReady;
    logic signed [7:0]  inData;
    logic signed [15:0] inScale;
    logic [3:0]         inShift;
`ifdef FXP_DEQ_ZP_EN
    logic signed [7:0]  inZp;
`endif
    logic               outValid;
    logic               outReady;
    logic signed [31:0] outData;
    logic               shiftClamped;

    always #5 clk = ~clk;

    fxp_dequant_stream dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (inValid),
        .in_ready      (inReady),
        .in_data       (inData),
        .in_scale      (inScale),
        .in_shift      (inShift),
`ifdef FXP_DEQ_ZP_EN
        .in_zp         (inZp),
`endif
        .out_valid     (outValid),
        .out_ready     (outReady),
        .out_data      (outData),
        .shift_clamped (shiftClamped)
    );

    typedef struct {
        logic signed [7:0]  data;
        logic signed [15:0] scale;
        logic [3:0]         shift;
        longint             expected;
    } vec_t;

    int     nVectors = 0;
    int     nMiscompares = 0;
    int     cycle = 0;
    longint expQ[$];
    longint curExp = 0;
    vec_t   vecs[10];

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    // Inputs change only just after posedge, so the negedge sees what the edge will take.
    always @(negedge clk) begin
        if (!rst) begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    failNow("unexpected output beat");
                end else begin
                    checkOutput("scoreboard out_data", outData, expQ.pop_front());
                end
            end
            if (inValid && inReady) begin
                expQ.push_back(curExp);
            end
        end
    end

    task automatic applyStimulus(input logic signed [7:0] d, input logic signed [15:0] sc,
                                 input logic [3:0] sh, input longint exp);
        int budget;
        budget  = 50;
        inValid = 1'b1;
        inData  = d;
        inScale = sc;
        inShift = sh;
        curExp  = exp;
        @(negedge clk);
        while (!inReady && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!inReady) failNow("accept timeout");
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 40;
        while (expQ.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (expQ.size() != 0) failNow("drain timeout");
        expQ.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int                 startCycle;
        int                 beat;
        int                 acceptCount;
        bit                 accepted;
        bit                 haveHeld;
        logic signed [31:0] heldData;

        vecs[0] = '{-128,      3,  4,      -6144};
        vecs[1] = '{ 127, -32768,  7, -532676608};
        vecs[2] = '{-128, -32768,  7,  536870912};
        vecs[3] = '{   1,      1, 10,        128};
        vecs[4] = '{   5,     -7,  2,       -140};
        vecs[5] = '{   0,   1234,  3,          0};
        vecs[6] = '{  -1,     -1,  0,          1};
        vecs[7] = '{ 100,    200, 15,    2560000};
        vecs[8] = '{ 127,  32767,  7,  532660352};
        vecs[9] = '{  -3,      5,  1,        -30};

        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        inScale  = '0;
        inShift  = '0;
        outReady = 1'b1;
`ifdef FXP_DEQ_ZP_EN
        inZp     = '0;
`endif
        #12;
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset out_data", outData, 0);
        checkOutput("reset shift_clamped", shiftClamped, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready after reset", inReady, 1);

        // Single beat: output valid exactly two cycles after the accepting edge's cycle.
        inValid = 1'b1;
        inData  = -128;
        inScale = 3;
        inShift = 4;
        curExp  = -6144;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("latency cycle1 out_valid", outValid, 0);
        @(posedge clk);
        #1;
        checkOutput("latency cycle2 out_valid", outValid, 1);
        checkOutput("latency out_data", outData, -6144);
        checkOutput("shift_clamped before clamp", shiftClamped, 0);
        waitDrain();

        startCycle = cycle;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].data, vecs[i].scale, vecs[i].shift, vecs[i].expected);
        end
        checkOutput("stream throughput cycles", cycle - startCycle, 10);
        waitDrain();
        checkOutput("shift_clamped after clamp", shiftClamped, 1);

        // Backpressure: four beats offered for five stalled cycles.
        outReady    = 1'b0;
        beat        = 1;
        acceptCount = 0;
        haveHeld    = 1'b0;
        heldData    = '0;
        for (int c = 0; c < 5; c++) begin
            inValid = 1'b1;
            inData  = 8'(beat);
            inScale = 1;
            inShift = 0;
            curExp  = beat;
            @(negedge clk);
            if (outValid) begin
                if (!haveHeld) begin
                    heldData = outData;
                    haveHeld = 1'b1;
                end else begin
                    checkOutput("stall out_data stable", outData, heldData);
                end
            end
            accepted = inReady;
            @(posedge clk);
            #1;
            if (accepted) begin
                acceptCount++;
                beat++;
            end
        end
        checkOutput("stall accept count", acceptCount, 2);
        checkOutput("stall in_ready low", inReady, 0);
        checkOutput("stall held data", heldData, 1);
        outReady = 1'b1;
        while (beat <= 4) begin
            applyStimulus(8'(beat), 1, 0, beat);
            beat++;
        end
        waitDrain();
        checkOutput("shift_clamped sticky", shiftClamped, 1);

`ifdef FXP_DEQ_ZP_EN
        inZp = 127;
        applyStimulus(-128, -32768, 7, 1069547520);
        inZp = 3;
        applyStimulus(10, 2, 1, 28);
        inZp = 0;
        waitDrain();
`endif

        // Fill both stages, then reset asynchronously mid-cycle.
        outReady = 1'b0;
        applyStimulus(11, 1, 0, 11);
        applyStimulus(22, 1, 0, 22);
        checkOutput("full pipe out_valid", outValid, 1);
        checkOutput("full pipe out_data", outData, 11);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset out_valid", outValid, 0);
        checkOutput("async reset out_data", outData, 0);
        checkOutput("async reset shift_clamped", shiftClamped, 0);
        expQ.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("no stale beat after reset", outValid, 0);
        end
        applyStimulus(77, 1, 0, 77);
        waitDrain();
        @(posedge clk);
        #1;
        checkOutput("idle out_valid at end", outValid, 0);
        checkOutput("shift_clamped after reset", shiftClamped, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
